// File: rtl/run_pkg.sv
// Shared types for the start/halt launch controller: FSM state encoding and
// the fixed data word written during the memory clear sweep.
package run_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARMED = 3'd1,
      ST_CLEAR = 3'd2,
      ST_RUN   = 3'd3,
      ST_DONE  = 3'd4
   } run_state_t;

   localparam logic [7:0] CLR_DATA = 8'h00;

endpackage

// File: rtl/run_cnt.sv
// Loadable, clearable, saturating up-counter. Priority: reset, clear, load,
// increment. Holds at all-ones instead of wrapping.
module run_cnt #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clr_i,
   input  logic         ld_i,
   input  logic [W-1:0] ld_val_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (ld_i) begin
         cnt_d = ld_val_i;
      end else if (inc_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/run_ctrl.sv
// Start/halt launch responder: arm on start high, launch on start low,
// optionally sweep data memory to zero, run the PC until halt op or watchdog.
module run_ctrl
   import run_pkg::*;
#(
   parameter int          DEPTH      = 256,
   parameter int          AW         = 8,
   parameter int          CNT_W      = 16,
   parameter int unsigned MAX_CYCLES = 60000,
   parameter bit          CLEAR_EN   = 1'b1
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             start,
   input  logic             done_instr,
   output logic             pc_reset,
   output logic             pc_en,
   output logic             clr_we,
   output logic [AW-1:0]    clr_addr,
   output logic             halt,
   output logic             timeout,
   output logic [CNT_W-1:0] cycle_count,
   output logic [2:0]       dbg_state
);

   run_state_t state_q, state_d;
   logic       launch, wdog_hit;
   logic       pc_reset_q, pc_en_q, clr_we_q, halt_q, timeout_q;
   logic       addr_clr;

   always_comb begin
      state_d  = state_q;
      launch   = 1'b0;
      wdog_hit = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_ARMED;
         end
         ST_ARMED: begin
            if (!start) begin
               launch  = 1'b1;
               state_d = CLEAR_EN ? ST_CLEAR : ST_RUN;
            end
         end
         ST_CLEAR: begin
            if (start) begin
               state_d = ST_ARMED;
            end else if (clr_addr == AW'(DEPTH - 1)) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            // Re-arm beats halt, and the halt op beats the watchdog.
            if (start) begin
               state_d = ST_ARMED;
            end else if (done_instr) begin
               state_d = ST_DONE;
            end else if (cycle_count == CNT_W'(MAX_CYCLES - 1)) begin
               state_d  = ST_DONE;
               wdog_hit = 1'b1;
            end
         end
         ST_DONE: begin
            if (start) state_d = ST_ARMED;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they leave a flop directly.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_q    <= ST_IDLE;
         pc_reset_q <= 1'b1;
         pc_en_q    <= 1'b0;
         clr_we_q   <= 1'b0;
         halt_q     <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_reset_q <= (state_d == ST_IDLE) || (state_d == ST_ARMED) || (state_d == ST_CLEAR);
         pc_en_q    <= (state_d == ST_RUN);
         clr_we_q   <= (state_d == ST_CLEAR);
         halt_q     <= (state_d == ST_DONE);
         if (launch) begin
            timeout_q <= 1'b0;
         end else if (wdog_hit) begin
            timeout_q <= 1'b1;
         end
      end
   end

   // The sweep address only advances while staying in CLEAR; any exit zeroes it.
   assign addr_clr = !((state_q == ST_CLEAR) && (state_d == ST_CLEAR));

   run_cnt #(.W(AW)) u_addr_cnt (
      .clk_i    (CLK),
      .rst_i    (Reset),
      .clr_i    (addr_clr),
      .ld_i     (1'b0),
      .ld_val_i ('0),
      .inc_i    (1'b1),
      .cnt_o    (clr_addr)
   );

   run_cnt #(.W(CNT_W)) u_cycle_cnt (
      .clk_i    (CLK),
      .rst_i    (Reset),
      .clr_i    (launch),
      .ld_i     (wdog_hit),
      .ld_val_i (CNT_W'(MAX_CYCLES)),
      .inc_i    (state_q == ST_RUN),
      .cnt_o    (cycle_count)
   );

   assign pc_reset  = pc_reset_q;
   assign pc_en     = pc_en_q;
   assign clr_we    = clr_we_q;
   assign halt      = halt_q;
   assign timeout   = timeout_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl: one instance with the clear sweep and a short
// watchdog, one with the sweep disabled.
module tb_run_ctrl;

   localparam int DEPTH = 256;
   localparam int AW    = 8;
   localparam int CNT_W = 16;
   localparam int MAXC  = 10;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ARMED = 3'd1;

   logic clk = 1'b0;
   logic rst;

   logic             start_a, done_a;
   logic             pc_reset_a, pc_en_a, clr_we_a, halt_a, timeout_a;
   logic [AW-1:0]    clr_addr_a;
   logic [CNT_W-1:0] count_a;
   logic [2:0]       state_a;

   logic             start_b, done_b;
   logic             pc_reset_b, pc_en_b, clr_we_b, halt_b, timeout_b;
   logic [AW-1:0]    clr_addr_b;
   logic [CNT_W-1:0] count_b;
   logic [2:0]       state_b;

   int            n_chk = 0;
   int            n_err = 0;
   logic [AW-1:0] exp_q[$];
   int            lat;
   int            k;
   int            hits;
   logic          b_we_seen = 1'b0;

   run_ctrl #(.DEPTH(DEPTH), .AW(AW), .CNT_W(CNT_W), .MAX_CYCLES(MAXC), .CLEAR_EN(1'b1)) dut_a (
      .CLK(clk), .Reset(rst), .start(start_a), .done_instr(done_a),
      .pc_reset(pc_reset_a), .pc_en(pc_en_a), .clr_we(clr_we_a), .clr_addr(clr_addr_a),
      .halt(halt_a), .timeout(timeout_a), .cycle_count(count_a), .dbg_state(state_a)
   );

   run_ctrl #(.DEPTH(DEPTH), .AW(AW), .CNT_W(CNT_W), .MAX_CYCLES(MAXC), .CLEAR_EN(1'b0)) dut_b (
      .CLK(clk), .Reset(rst), .start(start_b), .done_instr(done_b),
      .pc_reset(pc_reset_b), .pc_en(pc_en_b), .clr_we(clr_we_b), .clr_addr(clr_addr_b),
      .halt(halt_b), .timeout(timeout_b), .cycle_count(count_b), .dbg_state(state_b)
   );

   // clock / reset
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (clr_we_b) b_we_seen = 1'b1;
   end

   initial begin
      #1ms;
      $display("FAIL global_timeout: got no end, expected finish");
      $fatal(1);
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Drop start and follow dut_a to its first pc_en cycle, scoreboarding sweep addresses.
   task automatic launch_a(output int latency);
      int we_cycles;
      we_cycles = 0;
      latency   = 0;
      exp_q.delete();
      for (int i = 0; i < DEPTH; i++) exp_q.push_back(AW'(i));
      start_a = 1'b0;
      for (int i = 1; (i <= DEPTH + 50) && (latency == 0); i++) begin
         tick();
         if (clr_we_a) begin
            we_cycles++;
            if (exp_q.size() == 0) check("clr_extra_write", 32'(clr_addr_a), 32'hFFFF_FFFF);
            else check("clr_addr", 32'(clr_addr_a), 32'(exp_q.pop_front()));
         end
         if (pc_en_a) latency = i;
      end
      check("launch_seen", 32'(latency != 0), 32'd1);
      check("clr_we_cycles", 32'(we_cycles), 32'(DEPTH));
      check("sweep_complete", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      rst = 1'b1; start_a = 1'b0; done_a = 1'b0; start_b = 1'b0; done_b = 1'b0;
      tick(); tick();
      check("rst_state", 32'(state_a), 32'(S_IDLE));
      check("rst_pc_reset", 32'(pc_reset_a), 32'd1);
      check("rst_pc_en", 32'(pc_en_a), 32'd0);
      check("rst_clr_we", 32'(clr_we_a), 32'd0);
      check("rst_halt", 32'(halt_a), 32'd0);
      check("rst_count", 32'(count_a), 32'd0);
      rst = 1'b0;
      tick();

      // Full launch with sweep, halt op on the 5th RUN cycle.
      start_a = 1'b1; tick(); tick();
      check("armed_state", 32'(state_a), 32'(S_ARMED));
      check("armed_pc_reset", 32'(pc_reset_a), 32'd1);
      launch_a(lat);
      check("launch_latency", 32'(lat), 32'(DEPTH + 1));
      check("run_pc_reset", 32'(pc_reset_a), 32'd0);
      check("run_clr_addr", 32'(clr_addr_a), 32'd0);
      tick(); tick(); tick(); tick();
      check("run_count4", 32'(count_a), 32'd4);
      done_a = 1'b1; tick(); done_a = 1'b0;
      check("done_halt", 32'(halt_a), 32'd1);
      check("done_count", 32'(count_a), 32'd5);
      check("done_timeout", 32'(timeout_a), 32'd0);
      check("done_pc_en", 32'(pc_en_a), 32'd0);
      check("done_pc_reset", 32'(pc_reset_a), 32'd0);
      hits = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (!halt_a || count_a != 16'd5) hits++;
      end
      check("halt_hold", 32'(hits), 32'd0);
      start_a = 1'b1; tick();
      check("rearm_halt_low", 32'(halt_a), 32'd0);
      check("rearm_state", 32'(state_a), 32'(S_ARMED));

      // Watchdog expiry with no halt op.
      launch_a(lat);
      k = 0;
      while (!halt_a && k < 30) begin tick(); k++; end
      check("wdog_cycles", 32'(k), 32'(MAXC));
      check("wdog_timeout", 32'(timeout_a), 32'd1);
      check("wdog_count", 32'(count_a), 32'(MAXC));

      // Halt op on the very cycle the watchdog would fire.
      start_a = 1'b1; tick();
      launch_a(lat);
      for (int i = 0; i < MAXC - 1; i++) tick();
      done_a = 1'b1; tick(); done_a = 1'b0;
      check("tie_halt", 32'(halt_a), 32'd1);
      check("tie_timeout", 32'(timeout_a), 32'd0);
      check("tie_count", 32'(count_a), 32'(MAXC));

      // Abort the sweep at address 40, then relaunch from address 0.
      start_a = 1'b1; tick(); start_a = 1'b0;
      k = 0;
      do begin tick(); k++; end while (clr_addr_a != 8'd40 && k < 100);
      check("abort_at40_we", 32'(clr_we_a), 32'd1);
      start_a = 1'b1; tick();
      check("abort_clr_we", 32'(clr_we_a), 32'd0);
      check("abort_clr_addr", 32'(clr_addr_a), 32'd0);
      check("abort_state", 32'(state_a), 32'(S_ARMED));
      tick();
      launch_a(lat);
      check("relaunch_latency", 32'(lat), 32'(DEPTH + 1));

      // Abort RUN at count 3; halt must never rise.
      tick(); tick(); tick();
      check("run_abort_count3", 32'(count_a), 32'd3);
      start_a = 1'b1; tick();
      check("run_abort_state", 32'(state_a), 32'(S_ARMED));
      check("run_abort_pc_en", 32'(pc_en_a), 32'd0);
      hits = 0;
      for (int i = 0; i < 5; i++) begin tick(); if (halt_a) hits++; end
      check("run_abort_no_halt", 32'(hits), 32'd0);

      // Reset in RUN at count 7.
      launch_a(lat);
      for (int i = 0; i < 7; i++) tick();
      check("pre_reset_count7", 32'(count_a), 32'd7);
      rst = 1'b1; tick();
      check("mid_rst_state", 32'(state_a), 32'(S_IDLE));
      check("mid_rst_pc_reset", 32'(pc_reset_a), 32'd1);
      check("mid_rst_pc_en", 32'(pc_en_a), 32'd0);
      check("mid_rst_count", 32'(count_a), 32'd0);
      check("mid_rst_halt", 32'(halt_a), 32'd0);
      rst = 1'b0; tick();

      // Sweep disabled: one-cycle launch, halt op on the 3rd RUN cycle.
      start_b = 1'b1; tick(); tick(); start_b = 1'b0; tick();
      check("b_launch_pc_en", 32'(pc_en_b), 32'd1);
      check("b_launch_pc_reset", 32'(pc_reset_b), 32'd0);
      tick(); tick();
      done_b = 1'b1; tick(); done_b = 1'b0;
      check("b_halt", 32'(halt_b), 32'd1);
      check("b_count", 32'(count_b), 32'd3);
      check("b_timeout", 32'(timeout_b), 32'd0);
      check("b_never_cleared", 32'(b_we_seen), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
